fir_decim: RTL
==============

Name: fir_decim

Overview:
- Decimating FIR low-pass stage that sits directly upstream of the de-emphasis iir stage in the audio path.
- Reads 32-bit quantized samples from a show-ahead input FIFO and writes one filtered sample per DECIM inputs into the FIFO that feeds iir.
- Uses a single time-multiplexed multiply-accumulate unit driven by a three-state FSM.

Parameters:
- TAPS, 32, number of filter taps; must be a multiple of DECIM.
- DECIM, 8, decimation factor: input samples consumed per output sample.
- DATA_WIDTH, 32, sample, coefficient and accumulator width; all signed.
- QUANT_BITS, 10, fixed-point fraction bits (1.0 = 1024).
- COEFFS, all zeros, packed TAPS*DATA_WIDTH signed coefficient table; coefficient k occupies bits [k*32 +: 32].

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low.
- x_in_rd_en  out  1  pop strobe to the input FIFO.
- x_in_empty  in  1  input FIFO empty.
- x_in  in  32  input FIFO head word; show-ahead, valid whenever x_in_empty=0.
- y_out  out  32  filtered sample to the output FIFO.
- y_out_wr_en  out  1  write strobe to the output FIFO.
- y_out_full  in  1  output FIFO full.

Behaviour:
- Reset (reset=0, async):
  - State returns to S_FILL.
  - Shift register x[0..TAPS-1], accumulator, tap counter and fill counter clear to 0.
  - y_out=0, y_out_wr_en=0, x_in_rd_en=0.
- S_FILL:
  - x_in_rd_en = !x_in_empty (combinational).
  - On each pop, the sample shifts in with the newest at x[0]: x[j] <= x[j-1], x[0] <= x_in.
  - After DECIM pops this equals the block form: x[j] = old x[j-DECIM] for j ≥ DECIM, and x[DECIM-1-i] = in[i] for i = 0..DECIM-1.
  - After the DECIM-th pop: go to S_MAC, clear accumulator, tap counter = 0.
  - Empty FIFO stalls the state indefinitely with no pop.
- S_MAC:
  - One tap per cycle, j = 0..TAPS-1.
  - p = COEFFS[TAPS-1-j] * x[j], full 64-bit signed product.
  - Dequantize per product: truncate toward zero by QUANT_BITS (add 2^QUANT_BITS-1 before the arithmetic shift when p<0), then keep the low 32 bits.
  - acc <= acc + dq, with 32-bit two's-complement wrap and no saturation.
  - A pipeline register on the product is permitted; the total MAC duration must not exceed TAPS+2 cycles.
  - x_in_rd_en=0 throughout.
  - Go to S_WRITE when the last tap has been accumulated.
- S_WRITE:
  - y_out = acc.
  - y_out_wr_en = !y_out_full for exactly one cycle, then return to S_FILL.
  - While y_out_full=1: hold y_out, keep wr_en=0, read no input.
- Latency: first y_out_wr_en no later than TAPS+4 cycles after the DECIM-th pop, with both FIFOs unblocked.
- Throughput: at least one output per DECIM+TAPS+4 cycles when unblocked.
- x_in_rd_en and y_out_wr_en are never asserted in the same cycle.
- Reset mid-operation:
  - Any partial accumulation is discarded.
  - Samples already popped are lost.
  - The next output is computed from a zeroed history.
- Startup: history before the first input is zero; there is no pre-roll, and the first output is produced after DECIM inputs.

Test Plan:
- COEFFS[k]=k+1 (unquantized integers); inputs 1024 followed by 39 zeros -> outputs 25, 17, 9, 1, 0 in order, 5 writes total.
- All COEFFS=1024; 40 inputs of constant 100 -> outputs 800, 1600, 2400, 3200, 3200.
- All COEFFS=1; 8 inputs of -1 -> output 0 (truncation toward zero; floor would give -8). Repeat with +1023 -> 0.
- Backpressure: hold y_out_full=1 for 50 cycles at S_WRITE -> wr_en stays 0, y_out stable, x_in_rd_en=0; release -> exactly one write of the correct value.
- Starved input: assert x_in_empty for 1 of every 3 cycles during the boxcar test -> identical output sequence; rd_en never asserted while x_in_empty=1.
- Assert reset mid-S_MAC of the 3rd output, then feed 8 inputs of 100 (boxcar COEFFS) -> next output 800; all outputs read 0 during reset.

Source files
------------

// File: rtl/fir_decim.sv
// Decimating FIR low-pass stage: gathers DECIM samples from a show-ahead FIFO,
// runs one time-multiplexed MAC over all taps, and writes one sample downstream.
module fir_decim #(
  parameter int                              TAPS       = 32,
  parameter int                              DECIM      = 8,
  parameter int                              DATA_WIDTH = 32,
  parameter int                              QUANT_BITS = 10,
  parameter logic [TAPS*DATA_WIDTH-1:0]      COEFFS     = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  x_in_rd_en,
  input  logic                  x_in_empty,
  input  logic [DATA_WIDTH-1:0] x_in,
  output logic [DATA_WIDTH-1:0] y_out,
  output logic                  y_out_wr_en,
  input  logic                  y_out_full
);

  localparam int TAP_W  = (TAPS  > 1) ? $clog2(TAPS)  : 1;
  localparam int FILL_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic signed [2*DATA_WIDTH-1:0] TRUNC_BIAS = (2*DATA_WIDTH)'((64'sd1 <<< QUANT_BITS) - 64'sd1);

  typedef enum logic [1:0] {S_FILL, S_MAC, S_WRITE} state_t;

  state_t                        state;
  logic signed [DATA_WIDTH-1:0]  x [TAPS];
  logic signed [DATA_WIDTH-1:0]  acc;
  logic [TAP_W-1:0]              tap;
  logic [FILL_W-1:0]             fill;

  logic signed [DATA_WIDTH-1:0]   coeff;
  logic signed [DATA_WIDTH-1:0]   sample;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [2*DATA_WIDTH-1:0] prod_adj;
  logic signed [DATA_WIDTH-1:0]   dq;
  logic signed [DATA_WIDTH-1:0]   acc_next;

  // Newest sample lives at x[0], so tap j pairs with the coefficient from the far end.
  // NOTE: every always_comb output gets a value before any branch, so no latch is inferred.
  always_comb begin
    coeff    = COEFFS[(TAPS-1-int'(tap))*DATA_WIDTH +: DATA_WIDTH];
    sample   = x[tap];
    prod     = coeff * sample;
    // Bias negative products so the arithmetic shift truncates toward zero.
    prod_adj = prod[2*DATA_WIDTH-1] ? prod + TRUNC_BIAS : prod;
    dq       = DATA_WIDTH'(prod_adj >>> QUANT_BITS);
    acc_next = acc + dq;
  end

  // Gating with reset keeps the pop strobe quiet while reset is held.
  assign x_in_rd_en  = reset && (state == S_FILL) && !x_in_empty;
  assign y_out_wr_en = (state == S_WRITE) && !y_out_full;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_FILL;
      acc   <= '0;
      tap   <= '0;
      fill  <= '0;
      y_out <= '0;
      // NOTE: the history is flip-flops, not RAM, and must restart from zero, so it is reset.
      for (int j = 0; j < TAPS; j++) x[j] <= '0;
    end else begin
      case (state)
        S_FILL: begin
          if (x_in_rd_en) begin
            for (int j = TAPS-1; j > 0; j--) x[j] <= x[j-1];
            x[0] <= x_in;
            if (fill == FILL_W'(DECIM-1)) begin
              fill  <= '0;
              acc   <= '0;
              tap   <= '0;
              state <= S_MAC;
            end else begin
              fill <= fill + 1'b1;
            end
          end
        end
        S_MAC: begin
          acc <= acc_next;
          if (tap == TAP_W'(TAPS-1)) begin
            tap   <= '0;
            y_out <= acc_next;
            state <= S_WRITE;
          end else begin
            tap <= tap + 1'b1;
          end
        end
        S_WRITE: begin
          if (!y_out_full) state <= S_FILL;
        end
        default: state <= S_FILL;
      endcase
    end
  end

endmodule
